rgb_frame_fetch: RTL and testbench
==================================

// Module: rgb_frame_fetch
// PURPOSE
//  Downstream consumer of the YUV->RGB colourspace stage. Streams the finished
//  320x240 RGB image from SRAM (packed 3 words per 2 pixels) to the display path.
//  Output is a valid/ready pixel stream with end-of-line and end-of-frame flags.
//  A word FIFO with credit-based read issue keeps SRAM reads from overrunning downstream.
// PARAMETERS
//  RGB_BASE      146944  first SRAM word of the RGB image
//  IMG_WIDTH     320     pixels per line (must be even)
//  IMG_HEIGHT    240     lines per frame
//  FIFO_DEPTH    8       16-bit word FIFO entries (power of 2, >= READ_LATENCY+2)
//  READ_LATENCY  2       cycles from SRAM_address register to valid SRAM_read_data
// PORTS
//  Clock            in   1   system clock, all logic on rising edge
//  Resetn           in   1   asynchronous active-low reset
//  Start            in   1   1-cycle pulse; begins one frame when idle
//  Busy             out  1   high from accepted Start until Done
//  Done             out  1   1-cycle pulse after last pixel is accepted
//  SRAM_address     out  18  read address
//  SRAM_write_data  out  16  constant 0
//  SRAM_we_n        out  1   constant 1 (read only)
//  SRAM_read_data   in   16  read data, READ_LATENCY cycles after address
//  Pixel_valid      out  1   output pixel valid
//  Pixel_ready      in   1   downstream accepts when valid&ready
//  Pixel_R/G/B      out  8 each  pixel colour
//  Pixel_eol        out  1   qualifies pixel: last pixel of a line
//  Pixel_eof        out  1   qualifies pixel: last pixel of the frame
// BEHAVIOUR
//  Reset: SRAM_address=RGB_BASE, SRAM_we_n=1, SRAM_write_data=0. Busy, Done,
//   Pixel_valid, Pixel_R/G/B, Pixel_eol and Pixel_eof are 0. FIFO is empty,
//   the in-flight pipe is cleared and the FSM is in IDLE.
//  FSM: IDLE -Start-> FETCH. FETCH moves to DRAIN the cycle after the last read issues.
//   DRAIN -last pixel accepted-> DONE. DONE lasts 1 cycle (Done=1), then returns to IDLE.
//   Start is ignored outside IDLE.
//  Word total N = W*H*3/2 = 115200; addresses RGB_BASE..RGB_BASE+N-1 (=262143).
//   18-bit address never wraps; no read is issued past the last word.
//  Read issue: at most 1 read per cycle, in FETCH only.
//   Issue only when fifo_count + inflight < FIFO_DEPTH.
//   The inflight shift register (READ_LATENCY bits) tags returning data for FIFO write.
//  Packing: w0={R0,G0}, w1={B0,R1}, w2={G1,B1}. Unpacker phase P0/P1.
//   P0: valid when FIFO holds >=2 words; R=w0[15:8] G=w0[7:0] B=w1[15:8];
//    accept pops 1 word, then phase P1.
//   P1: valid when FIFO holds >=2 words (w1,w2); R=w1[7:0] G=w2[15:8]
//    B=w2[7:0]; accept pops 2 words, then phase P0.
//  Pixel outputs are registered. While valid&!ready, all Pixel_* hold stable.
//   Valid never drops without an accept.
//  FIFO may write and pop in the same cycle; count updates by (+1 - pops).
//   Overflow is impossible by credit rule; underflow is impossible by the >=2 check.
//  col (0..W-1) and row (0..H-1) advance on accept.
//   Pixel_eol = (col==W-1); Pixel_eof = eol & (row==H-1).
//  Throughput: SRAM-bound, 2 pixels per 3 cycles when ready is held high.
//  Reset mid-frame: immediate return to reset values. Data still in flight is
//   discarded. The next Start fetches from RGB_BASE, pixel 0.
// TESTING
//  Full frame, ready=1, SRAM word[a]=a[15:0]:
//   -> pixel0 R=3E G=00 B=3E; pixel1 R=01 G=3E B=02.
//   -> 76800 pixels total; last read address is 262143; Done pulses once after the final accept.
//  Random Pixel_ready (30% low):
//   -> pixel stream identical to the ready=1 run.
//   -> fifo_count+inflight never exceeds 8 (assertion).
//  Ready low for 1000 cycles after pixel 10:
//   -> reads stop once credits are exhausted.
//   -> Pixel_* frozen on pixel 10 until ready rises.
//  Flags: eol=1 only at pixel indices 319, 639, ...; eof=1 only at index 76799.
//   The first pixel of each line follows eol with no gap when ready=1.
//  Resetn pulsed low at pixel 5000:
//   -> outputs take reset values asynchronously.
//   -> a new Start yields pixel0 from address 146944 again.
//  Start pulses during FETCH/DRAIN are ignored: exactly 1 Done, 76800 pixels.

Source files
------------

// File: rtl/rgb_frame_fetch.sv
// Streams a finished RGB frame (3 SRAM words per 2 pixels) out as a valid/ready pixel stream.
// SRAM reads are issued against free FIFO credit, so returning data always has a slot.
module rgb_frame_fetch #(
  parameter int RGB_BASE     = 146944,
  parameter int IMG_WIDTH    = 320,
  parameter int IMG_HEIGHT   = 240,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        Pixel_valid,
  input  logic        Pixel_ready,
  output logic [7:0]  Pixel_R,
  output logic [7:0]  Pixel_G,
  output logic [7:0]  Pixel_B,
  output logic        Pixel_eol,
  output logic        Pixel_eof
);

  // state  | meaning
  // IDLE   | waiting for Start
  // FETCH  | issuing SRAM reads while credit allows
  // DRAIN  | all reads issued, emptying FIFO to the pixel stream
  // DONE   | one-cycle Done pulse

  localparam int WORDS = IMG_WIDTH * IMG_HEIGHT * 3 / 2;
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CNTW  = PW + 1;

  localparam logic [17:0]   BASE_ADDR = 18'(RGB_BASE);
  localparam logic [17:0]   WORDS_U   = 18'(WORDS);
  localparam logic [CNTW:0] DEPTH_U   = (CNTW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [17:0]             rd_addr;
  logic [17:0]             rd_left;
  logic [READ_LATENCY-1:0] inflight;
  logic [CNTW-1:0]         inflight_cnt;
  logic [CNTW:0]           used_words;

  logic [15:0]     fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_count;
  logic            fifo_wr;
  logic [CNTW-1:0] pop_n;
  logic [15:0]     w_a, w_b;

  logic          phase;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic start_go, issue, last_issue, accept, load;

  assign SRAM_write_data = 16'd0;
  assign SRAM_we_n       = 1'b1;

  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      inflight_cnt = inflight_cnt + CNTW'(inflight[i]);
  end

  assign used_words = {1'b0, fifo_count} + {1'b0, inflight_cnt};
  assign issue      = (state == S_FETCH) && (rd_left != 18'd0) && (used_words < DEPTH_U);
  assign last_issue = issue && (rd_left == 18'd1);
  assign fifo_wr    = inflight[READ_LATENCY-1];
  assign accept     = Pixel_valid && Pixel_ready;

  // A pixel moves into the output register as soon as the slot frees up and two words are queued.
  assign load  = (!Pixel_valid || Pixel_ready) && (fifo_count >= CNTW'(2));
  assign pop_n = !load ? CNTW'(0) : (phase ? CNTW'(2) : CNTW'(1));
  assign w_a   = fifo_mem[rd_ptr];
  assign w_b   = fifo_mem[rd_ptr + PW'(1)];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_go  = 1'b0;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (Start) begin
          start_go  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        Busy = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        Busy = 1'b1;
        if (accept && Pixel_eof) state_nxt = S_DONE;
      end
      S_DONE: begin
        Done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The address holds on the final word so it never steps past the image.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      SRAM_address <= BASE_ADDR;
      rd_addr      <= BASE_ADDR;
      rd_left      <= 18'd0;
      inflight     <= '0;
    end else begin
      inflight <= (inflight << 1) | READ_LATENCY'(issue);
      if (start_go) begin
        rd_addr <= BASE_ADDR;
        rd_left <= WORDS_U;
      end else if (issue) begin
        SRAM_address <= rd_addr;
        rd_left      <= rd_left - 18'd1;
        if (rd_left != 18'd1) rd_addr <= rd_addr + 18'd1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= SRAM_read_data;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      wr_ptr     <= wr_ptr + PW'(fifo_wr);
      rd_ptr     <= rd_ptr + PW'(pop_n);
      fifo_count <= fifo_count + CNTW'(fifo_wr) - pop_n;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Pixel_valid <= 1'b0;
      Pixel_R     <= 8'd0;
      Pixel_G     <= 8'd0;
      Pixel_B     <= 8'd0;
      Pixel_eol   <= 1'b0;
      Pixel_eof   <= 1'b0;
      phase       <= 1'b0;
      col         <= '0;
      row         <= '0;
    end else begin
      if (load)             Pixel_valid <= 1'b1;
      else if (Pixel_ready) Pixel_valid <= 1'b0;

      if (start_go) begin
        phase <= 1'b0;
        col   <= '0;
        row   <= '0;
      end else if (load) begin
        if (!phase) begin
          Pixel_R <= w_a[15:8];
          Pixel_G <= w_a[7:0];
          Pixel_B <= w_b[15:8];
        end else begin
          Pixel_R <= w_a[7:0];
          Pixel_G <= w_b[15:8];
          Pixel_B <= w_b[7:0];
        end
        Pixel_eol <= (col == COL_LAST);
        Pixel_eof <= (col == COL_LAST) && (row == ROW_LAST);
        phase     <= ~phase;
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_frame_fetch.sv
// Scoreboard bench for rgb_frame_fetch on a small 8x4 frame; the SRAM returns its own address.
module tb_rgb_frame_fetch;

  localparam int BASE  = 146944;
  localparam int W     = 8;
  localparam int H     = 4;
  localparam int NPIX  = W * H;
  localparam int NWORD = NPIX * 3 / 2;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        Start = 1'b0;
  logic        Pixel_ready = 1'b0;
  logic        Busy, Done, SRAM_we_n, Pixel_valid, Pixel_eol, Pixel_eof;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data, SRAM_read_data;
  logic [7:0]  Pixel_R, Pixel_G, Pixel_B;
  logic [15:0] sram_q;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       eol;
    logic       eof;
  } pix_t;

  pix_t        exp_q[$];
  int          tests = 0, fails = 0;
  int          px_cnt = 0, done_cnt = 0, mode = 0, stall_cnt = 0, max_used = 0;
  logic [17:0] stall_addr_a, stall_addr_b;
  logic        prev_hold = 1'b0;
  pix_t        prev_pix;

  rgb_frame_fetch #(.RGB_BASE(BASE), .IMG_WIDTH(W), .IMG_HEIGHT(H),
                    .FIFO_DEPTH(8), .READ_LATENCY(2)) dut (
    .Clock(Clock), .Resetn(Resetn), .Start(Start), .Busy(Busy), .Done(Done),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data),
    .Pixel_valid(Pixel_valid), .Pixel_ready(Pixel_ready),
    .Pixel_R(Pixel_R), .Pixel_G(Pixel_G), .Pixel_B(Pixel_B),
    .Pixel_eol(Pixel_eol), .Pixel_eof(Pixel_eof));

  always #5 Clock = ~Clock;

  // SRAM model: word[a] = a[15:0], data valid two edges after the address is registered
  always @(posedge Clock) sram_q <= SRAM_address[15:0];
  assign SRAM_read_data = sram_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic pix_t model(input int i);
    pix_t p;
    int a0;
    logic [15:0] w0, w1, w2;
    a0 = BASE + 3 * (i / 2);
    w0 = a0[15:0];
    w1 = w0 + 16'd1;
    w2 = w0 + 16'd2;
    if (i % 2 == 0) begin
      p.r = w0[15:8]; p.g = w0[7:0]; p.b = w1[15:8];
    end else begin
      p.r = w1[7:0]; p.g = w2[15:8]; p.b = w2[7:0];
    end
    p.eol = ((i % W) == W - 1);
    p.eof = (i == NPIX - 1);
    return p;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      if (i == 0)      exp_q.push_back({8'h3E, 8'h00, 8'h3E, 1'b0, 1'b0});
      else if (i == 1) exp_q.push_back({8'h01, 8'h3E, 8'h02, 1'b0, 1'b0});
      else             exp_q.push_back(model(i));
    end
  endtask

  // Monitor: pops the scoreboard on every accept and checks that stalled outputs hold
  always @(negedge Clock) begin
    pix_t cur, e;
    if (Resetn) begin
      cur = {Pixel_R, Pixel_G, Pixel_B, Pixel_eol, Pixel_eof};
      if (prev_hold) check("hold_stable", {5'd0, Pixel_valid, cur}, {5'd0, 1'b1, prev_pix});
      if (Pixel_valid && Pixel_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pixel: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("pixel%0d", px_cnt), {6'd0, cur}, {6'd0, e});
        end
        px_cnt++;
      end
      prev_hold = Pixel_valid && !Pixel_ready;
      prev_pix  = cur;
      if (Done) done_cnt++;
      if (int'(dut.used_words) > max_used) max_used = int'(dut.used_words);
    end else begin
      prev_hold = 1'b0;
    end
  end

  // Ready driver: 0 = always ready, 1 = ~30% low, 2 = stall 200 cycles on pixel 10
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      case (mode)
        0: Pixel_ready = 1'b1;
        1: Pixel_ready = ($urandom_range(0, 9) >= 3);
        default: begin
          if (px_cnt == 10 && stall_cnt < 200) begin
            Pixel_ready = 1'b0;
            stall_cnt++;
            if (stall_cnt == 50)  stall_addr_a = SRAM_address;
            if (stall_cnt == 199) stall_addr_b = SRAM_address;
          end else begin
            Pixel_ready = 1'b1;
          end
        end
      endcase
    end
  end

  task automatic pulse_start();
    @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge Clock);
      n++;
    end
    if (done_cnt == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no Done after %0d cycles expected Done", budget);
    end
  endtask

  task automatic run_frame(input string tag, input bit extra_starts);
    px_cnt   = 0;
    done_cnt = 0;
    push_frame();
    pulse_start();
    check({tag, "_busy"}, {31'd0, Busy}, 32'd1);
    if (extra_starts) begin
      for (int c = 0; c < 60; c++) begin
        @(negedge Clock);
        Start = (c == 15 || c == 35 || c == 55);
      end
      Start = 1'b0;
    end
    wait_done(3000);
    repeat (5) @(negedge Clock);
    check({tag, "_done_count"}, done_cnt, 32'd1);
    check({tag, "_pixel_count"}, px_cnt, NPIX);
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
    check({tag, "_busy_low"}, {31'd0, Busy}, 32'd0);
    check({tag, "_last_addr"}, {14'd0, SRAM_address}, BASE + NWORD - 1);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    check("rst_addr", {14'd0, SRAM_address}, BASE);
    check("rst_we_n", {31'd0, SRAM_we_n}, 32'd1);
    check("rst_wdata", {16'd0, SRAM_write_data}, 32'd0);
    check("rst_ctrl", {29'd0, Busy, Done, Pixel_valid}, 32'd0);
    check("rst_pixel", {6'd0, Pixel_R, Pixel_G, Pixel_B, Pixel_eol, Pixel_eof}, 32'd0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);

    mode = 0;
    run_frame("ready_high", 1'b0);

    mode = 1;
    run_frame("ready_random", 1'b1);

    mode = 2;
    stall_cnt = 0;
    run_frame("ready_stall", 1'b0);
    check("stall_len", stall_cnt, 32'd200);
    check("stall_reads_stop", {14'd0, stall_addr_b}, {14'd0, stall_addr_a});

    mode = 0;
    px_cnt = 0;
    done_cnt = 0;
    push_frame();
    pulse_start();
    for (int n = 0; n < 500 && px_cnt < 20; n++) @(negedge Clock);
    check("reached_pixel20", (px_cnt >= 20) ? 32'd1 : 32'd0, 32'd1);
    #2 Resetn = 1'b0;
    #1;
    check("midrst_addr", {14'd0, SRAM_address}, BASE);
    check("midrst_ctrl", {29'd0, Busy, Done, Pixel_valid}, 32'd0);
    check("midrst_pixel", {6'd0, Pixel_R, Pixel_G, Pixel_B, Pixel_eol, Pixel_eof}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    repeat (2) @(negedge Clock);
    run_frame("after_reset", 1'b0);

    check("credit_bound", (max_used <= 8) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
